// File: rtl/an3_pkg.sv
// Shared types and helpers for the bit-serial AN (A=3) code decoder.
//   state_t       : decoder FSM states IDLE / SHIFT / DONE
//   residue_t     : 2-bit running remainder (encodings 00/01/10; 11 unused)
//   ERR_CNT_W     : width of the optional error counter
//   next_residue  : one long-division step by 3, returns {q_bit, r_next}
package an3_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic [1:0] residue_t;

  localparam int ERR_CNT_W = 8;

  // t = 2*r + b lies in 0..5, so one conditional subtract of 3 is enough.
  // The unreachable residue 11 is treated as 0 so a corrupted register can
  // never propagate an out-of-range remainder.
  function automatic logic [2:0] next_residue(input residue_t r, input logic b);
    residue_t   r_eff;
    logic [2:0] t;
    logic [2:0] d;
    r_eff = (r == 2'd3) ? 2'd0 : r;
    t     = {r_eff, b};
    d     = t - 3'd3;
    if (t >= 3'd3) begin
      return {1'b1, d[1:0]};
    end
    return {1'b0, t[1:0]};
  endfunction

endpackage

// File: rtl/an3_step.sv
// One combinational divide-by-3 step.
//   r      : current remainder
//   b      : next dividend bit (MSB first)
//   r_next : remainder after this step
//   q_bit  : quotient bit produced by this step
module an3_step
  import an3_pkg::*;
(
  input  residue_t r,
  input  logic     b,
  output residue_t r_next,
  output logic     q_bit
);

  logic [2:0] step;

  assign step   = next_residue(r, b);
  assign q_bit  = step[2];
  assign r_next = step[1:0];

endmodule

// File: rtl/an3_decoder.sv
// Bit-serial decoder for the AN (A=3) residue code. Divides a CODE_W-bit code
// word by 3, MSB first, one bit per clock, and reports the quotient, the final
// remainder and an error flag (non-zero remainder or quotient overflow).
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   code_i, in_valid    : input word and its valid
//   in_ready            : high only in IDLE
//   dat_o               : quotient, low DATA_W bits
//   reminder            : final remainder 0..2
//   err_o               : remainder != 0 or quotient does not fit DATA_W
//   out_valid, out_ready: result handshake
//   err_cnt             : saturating count of erroneous results delivered;
//                         present only when AN3_DEC_ERR_CNT_EN is defined
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. A producer holding valid keeps its data stable until the transfer;
// ready may be low for any number of cycles. Input is accepted only in IDLE,
// the result is held in DONE until out_ready, so accept and output handshake
// never share a cycle.
module an3_decoder
  import an3_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CODE_W = DATA_W + 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CODE_W-1:0]    code_i,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATA_W-1:0]    dat_o,
  output logic [1:0]           reminder,
  output logic                 err_o,
`ifdef AN3_DEC_ERR_CNT_EN
  output logic [ERR_CNT_W-1:0] err_cnt,
`endif
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int CNT_W = $clog2(CODE_W);

  state_t              state;
  state_t              state_nxt;
  logic [CODE_W-1:0]   shift_q;
  logic [CODE_W-1:0]   quot_q;
  logic [CODE_W-1:0]   quot_nxt;
  residue_t            r_q;
  residue_t            r_next;
  logic                q_bit;
  logic [CNT_W-1:0]    cnt_q;
  logic                accept;
  logic                last_bit;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign last_bit = (cnt_q == '0);

  an3_step u_step (
    .r      (r_q),
    .b      (shift_q[CODE_W-1]),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  // Quotient including the bit produced this cycle; on the last step this is
  // the complete CODE_W-bit quotient.
  assign quot_nxt = {quot_q[CODE_W-2:0], q_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)    state_nxt = SHIFT;
      SHIFT:   if (last_bit)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      quot_q    <= '0;
      r_q       <= '0;
      cnt_q     <= '0;
      dat_o     <= '0;
      reminder  <= '0;
      err_o     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            shift_q <= code_i;
            quot_q  <= '0;
            r_q     <= '0;
            cnt_q   <= CNT_W'(CODE_W - 1);
          end
        end
        SHIFT: begin
          shift_q <= {shift_q[CODE_W-2:0], 1'b0};
          quot_q  <= quot_nxt;
          r_q     <= r_next;
          if (last_bit) begin
            dat_o     <= quot_nxt[DATA_W-1:0];
            reminder  <= r_next;
            err_o     <= (r_next != 2'd0) || (|quot_nxt[CODE_W-1:DATA_W]);
            out_valid <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef AN3_DEC_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (out_valid && out_ready && err_o && (err_cnt != {ERR_CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule
